stream_byte_packer: RTL

//  Downstream neighbour of the barrel-shifter stage. Consumes beats already rotated so payload

---
 rtl/stream_pkg.sv | 20 ++
 rtl/byte_mask_gen.sv | 16 +
 rtl/stream_byte_packer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream byte packer
package stream_pkg;

  localparam int BYTES  = 64;
  localparam int DATA_W = 8 * BYTES;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  keep;
    logic              last;
    logic              last_xfer;
  } beat_t;

  typedef enum logic {ACCUM, FLUSH} state_e;

  function automatic logic [DATA_W-1:0] expand_keep(input logic [BYTES-1:0] keep);
    for (int i = 0; i < BYTES; i++) expand_keep[8*i +: 8] = {8{keep[i]}};
  endfunction

endpackage

// File: rtl/byte_mask_gen.sv
// rtl/byte_mask_gen.sv - byte count to thermometer keep mask (low count bytes set)
module byte_mask_gen
  import stream_pkg::*;
#(
  parameter int WIDTH = BYTES,
  parameter int CNT_W = 7
) (
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] mask
);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) mask[i] = (CNT_W'(i) < count);
  end

endmodule

// File: rtl/stream_byte_packer.sv
// rtl/stream_byte_packer.sv - merges pre-rotated partial beats into dense full-width stream beats
module stream_byte_packer #(
  parameter int BYTES = stream_pkg::BYTES,
  parameter int CNT_W = 7
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [8*BYTES-1:0]   data_in,
  input  logic [BYTES-1:0]     keep_in,
  input  logic [CNT_W-1:0]     count_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  input  logic                 last_xfer_in,
  output logic                 in_ready,
  output logic [8*BYTES-1:0]   m_data,
  output logic [BYTES-1:0]     m_keep,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 m_last_xfer,
  input  logic                 m_ready,
  output logic [$clog2(BYTES)-1:0] fill_out,
  output logic                 align_err
);
  import stream_pkg::*;

  localparam int DW = 8 * BYTES;
  localparam int FW = $clog2(BYTES);

  state_e           state_q, state_d;
  logic [DW-1:0]    acc_q, acc_d, merged;
  logic [FW-1:0]    fill_q, fill_d;
  logic             xfer_q, xfer_d;
  logic             align_err_q;
  beat_t            out_q, out_d;
  logic             out_valid_q;
  logic             emit, accept;
  logic [BYTES-1:0] fill_mask, keep_mask, cur_keep, ovf_keep;
  logic [CNT_W-1:0] sum, keep_cnt;

  assign in_ready = (state_q == ACCUM) & (~out_valid_q | m_ready);
  assign accept   = valid_in & in_ready;
  assign sum      = CNT_W'(fill_q) + count_in;
  assign cur_keep = keep_in & ~fill_mask;
  assign ovf_keep = keep_in & fill_mask;
  assign merged   = acc_q | (data_in & expand_keep(cur_keep));

  // In FLUSH the output mask covers the residual fill; otherwise the post-merge byte count
  assign keep_cnt = (state_q == FLUSH)         ? CNT_W'(fill_q) :
                    (sum >= CNT_W'(BYTES))     ? CNT_W'(BYTES)  : sum;

  byte_mask_gen #(.WIDTH(BYTES), .CNT_W(CNT_W)) u_fill_mask (
    .count (CNT_W'(fill_q)),
    .mask  (fill_mask)
  );

  byte_mask_gen #(.WIDTH(BYTES), .CNT_W(CNT_W)) u_keep_mask (
    .count (keep_cnt),
    .mask  (keep_mask)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    xfer_d  = xfer_q;
    emit    = 1'b0;
    out_d   = '0;
    case (state_q)
      ACCUM: begin
        if (accept && !(count_in == '0 && !last_in)) begin
          if (sum >= CNT_W'(BYTES)) begin
            emit            = 1'b1;
            out_d.data      = merged;
            out_d.keep      = '1;
            out_d.last      = last_in && (sum == CNT_W'(BYTES));
            out_d.last_xfer = last_in && (sum == CNT_W'(BYTES)) && last_xfer_in;
            acc_d           = data_in & expand_keep(ovf_keep);
            fill_d          = FW'(sum - CNT_W'(BYTES));
            if (last_in && sum > CNT_W'(BYTES)) begin
              state_d = FLUSH;
              xfer_d  = last_xfer_in;
            end
          end else if (!last_in) begin
            acc_d  = merged;
            fill_d = FW'(sum);
          end else begin
            emit            = 1'b1;
            out_d.data      = merged;
            out_d.keep      = keep_mask;
            out_d.last      = 1'b1;
            out_d.last_xfer = last_xfer_in;
            acc_d           = '0;
            fill_d          = '0;
          end
        end
      end
      FLUSH: begin
        if (!out_valid_q || m_ready) begin
          emit            = 1'b1;
          out_d.data      = acc_q;
          out_d.keep      = keep_mask;
          out_d.last      = 1'b1;
          out_d.last_xfer = xfer_q;
          acc_d           = '0;
          fill_d          = '0;
          state_d         = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      xfer_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      xfer_q  <= xfer_d;
      if (emit) begin
        out_q       <= out_d;
        out_valid_q <= 1'b1;
      end else if (m_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && (count_in > CNT_W'(BYTES) || (count_in != '0 && !keep_in[fill_q])))
        align_err_q <= 1'b1;
    end
  end

  // Bytes above the fill point must stay clear, or later merges would corrupt them
  always_ff @(posedge aclk) begin
    if (aresetn && !align_err_q) assert ((acc_q & ~expand_keep(fill_mask)) == '0);
  end

  assign m_data      = out_q.data;
  assign m_keep      = out_q.keep;
  assign m_last      = out_q.last;
  assign m_last_xfer = out_q.last_xfer;
  assign m_valid     = out_valid_q;
  assign fill_out    = fill_q;
  assign align_err   = align_err_q;

endmodule
